// File: rtl/int_div_rem_fu.sv
// rtl/int_div_rem_fu.sv - iterative radix-2 restoring divide/remainder unit for RV32M DIV/DIVU/REM/REMU
// Optional early termination (divisor zero, signed overflow, |Rs1|<|Rs2|) under IDRFU_EARLY_TERM_EN.
module int_div_rem_fu #(
    parameter int RSZ = 32
) (
    input  logic           clk_in,
    input  logic           reset_in,
    input  logic [RSZ-1:0] Rs1_data,
    input  logic [RSZ-1:0] Rs2_data,
    input  logic [1:0]     op,
    input  logic           start,
    output logic [RSZ-1:0] quotient,
    output logic [RSZ-1:0] remainder,
    output logic           done
);
    localparam int CW = $clog2(RSZ);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

    // op encoding: DIV=00, DIVU=01, REM=10, REMU=11; bit 0 set means unsigned
    localparam logic [RSZ-1:0] MIN_NEG = {1'b1, {(RSZ-1){1'b0}}};

    logic [1:0]     state_q, state_d;
    logic [CW-1:0]  count_q, count_d;
    logic [RSZ-1:0] rem_q, rem_d;
    logic [RSZ-1:0] dvd_q, dvd_d;
    logic [RSZ-1:0] dsr_q, dsr_d;
    logic           neg_quot_q, neg_quot_d;
    logic           neg_rem_q, neg_rem_d;
    logic           div0_q, div0_d;
    logic           ovf_q, ovf_d;
    logic [RSZ-1:0] quot_q, quot_d;
    logic [RSZ-1:0] rmd_q, rmd_d;
    logic           done_q, done_d;

    logic           is_signed;
    logic           is_div0;
    logic           is_ovf;
    logic [RSZ-1:0] abs1;
    logic [RSZ-1:0] abs2;
    logic [RSZ:0]   trial;
    logic           fits;
    logic [RSZ-1:0] sub;
    logic [RSZ-1:0] fix_quot;
    logic [RSZ-1:0] fix_rem;

    always_comb begin
        is_signed = ~op[0];
        is_div0   = (Rs2_data == '0);
        is_ovf    = is_signed && (Rs1_data == MIN_NEG) && (Rs2_data == '1);
        abs1      = (is_signed && Rs1_data[RSZ-1]) ? -Rs1_data : Rs1_data;
        abs2      = (is_signed && Rs2_data[RSZ-1]) ? -Rs2_data : Rs2_data;
        // rem < divisor always holds, so the true difference fits in RSZ bits
        trial     = {rem_q, dvd_q[RSZ-1]};
        fits      = (trial >= {1'b0, dsr_q});
        sub       = trial[RSZ-1:0] - dsr_q;
        fix_quot  = neg_quot_q ? -dvd_q : dvd_q;
        fix_rem   = neg_rem_q ? -rem_q : rem_q;
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        rem_d      = rem_q;
        dvd_d      = dvd_q;
        dsr_d      = dsr_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        div0_d     = div0_q;
        ovf_d      = ovf_q;
        quot_d     = quot_q;
        rmd_d      = rmd_q;
        done_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    rem_d      = '0;
                    dvd_d      = abs1;
                    dsr_d      = abs2;
                    neg_quot_d = is_signed & (Rs1_data[RSZ-1] ^ Rs2_data[RSZ-1]);
                    neg_rem_d  = is_signed & Rs1_data[RSZ-1];
                    div0_d     = is_div0;
                    ovf_d      = is_ovf;
                    count_d    = CW'(RSZ - 1);
                    state_d    = ST_CALC;
`ifdef IDRFU_EARLY_TERM_EN
                    if (is_div0 || is_ovf || (abs1 < abs2)) begin
                        rem_d   = abs1;
                        dvd_d   = '0;
                        state_d = ST_FIX;
                    end
`endif
                end
            end
            ST_CALC: begin
                rem_d = fits ? sub : trial[RSZ-1:0];
                dvd_d = {dvd_q[RSZ-2:0], fits};
                if (count_q == '0) begin
                    state_d = ST_FIX;
                end else begin
                    count_d = count_q - CW'(1);
                end
            end
            ST_FIX: begin
                quot_d  = ovf_q ? MIN_NEG : (div0_q ? '1 : fix_quot);
                rmd_d   = ovf_q ? '0 : fix_rem;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            rem_q      <= '0;
            dvd_q      <= '0;
            dsr_q      <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            div0_q     <= 1'b0;
            ovf_q      <= 1'b0;
            quot_q     <= '0;
            rmd_q      <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            rem_q      <= rem_d;
            dvd_q      <= dvd_d;
            dsr_q      <= dsr_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            div0_q     <= div0_d;
            ovf_q      <= ovf_d;
            quot_q     <= quot_d;
            rmd_q      <= rmd_d;
            done_q     <= done_d;
        end
    end

    assign quotient  = quot_q;
    assign remainder = rmd_q;
    assign done      = done_q;
endmodule

// File: tb/tb_int_div_rem_fu.sv
// tb/tb_int_div_rem_fu.sv - self-checking bench for int_div_rem_fu
module tb_int_div_rem_fu;
    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    logic        clk_in   = 1'b0;
    logic        reset_in = 1'b1;
    logic [31:0] rs1      = '0;
    logic [31:0] rs2      = '0;
    logic [1:0]  op       = '0;
    logic        start    = 1'b0;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        done;

    int_div_rem_fu #(.RSZ(32)) dut (
        .clk_in    (clk_in),
        .reset_in  (reset_in),
        .Rs1_data  (rs1),
        .Rs2_data  (rs2),
        .op        (op),
        .start     (start),
        .quotient  (quotient),
        .remainder (remainder),
        .done      (done)
    );

    always #5 clk_in = ~clk_in;

    int edge_cnt = 0;
    always @(posedge clk_in) edge_cnt <= edge_cnt + 1;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        int          lat;
        int          t0;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  o;
        logic [31:0] q;
        logic [31:0] r;
    } vec_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [63:0] ref_model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] o);
        logic signed [31:0] sq;
        logic signed [31:0] sr;
        if (b == 32'h0) return {32'hFFFF_FFFF, a};
        if (!o[0]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h8000_0000, 32'h0};
            sq = $signed(a) / $signed(b);
            sr = $signed(a) % $signed(b);
            return {sq, sr};
        end
        return {a / b, a % b};
    endfunction

    function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b, input logic [1:0] o);
`ifdef IDRFU_EARLY_TERM_EN
        logic [31:0] ma;
        logic [31:0] mb;
        ma = (!o[0] && a[31]) ? -a : a;
        mb = (!o[0] && b[31]) ? -b : b;
        if (b == 32'h0 || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) || ma < mb) return 1;
`endif
        return 33;
    endfunction

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [1:0] o,
                         input logic [31:0] eq, input logic [31:0] er);
        exp_t e;
        rs1   = a;
        rs2   = b;
        op    = o;
        start = 1'b1;
        @(posedge clk_in);
        #1;
        start = 1'b0;
        rs1   = $urandom;
        rs2   = $urandom;
        op    = 2'($urandom);
        e.q   = eq;
        e.r   = er;
        e.lat = exp_lat(a, b, o);
        e.t0  = edge_cnt;
        sb.push_back(e);
    endtask

    task automatic issue_ref(input logic [31:0] a, input logic [31:0] b, input logic [1:0] o);
        logic [63:0] qr;
        qr = ref_model(a, b, o);
        issue(a, b, o, qr[63:32], qr[31:0]);
    endtask

    task automatic wait_done(input int max_cycles);
        int k;
        k = 0;
        do begin
            @(negedge clk_in);
            k++;
        end while (!done && k < max_cycles);
        if (!done) begin
            n_checks++;
            $display("FAIL done_timeout: no done after %0d cycles, required done", k);
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    logic prev_done = 1'b0;
    always @(negedge clk_in) begin
        exp_t e;
        if (reset_in) begin
            prev_done = 1'b0;
        end else begin
            if (done) begin
                check("done_width", {31'b0, prev_done}, 32'h0);
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_done: got done with empty scoreboard, required no done");
                end else begin
                    e = sb.pop_front();
                    check("quotient", quotient, e.q);
                    check("remainder", remainder, e.r);
                    check("latency", 32'(edge_cnt - e.t0), 32'(e.lat));
                end
            end
            prev_done = done;
        end
    end

    vec_t vecs[13];
    int   ndone;

    initial begin
        vecs[0]  = '{32'd100,        32'd7,          OP_DIVU, 32'd14,         32'd2};
        vecs[1]  = '{32'hFFFF_FFF9,  32'd2,          OP_DIV,  32'hFFFF_FFFD,  32'hFFFF_FFFF};
        vecs[2]  = '{32'hFFFF_FFF9,  32'd2,          OP_REM,  32'hFFFF_FFFD,  32'hFFFF_FFFF};
        vecs[3]  = '{32'h8000_0000,  32'hFFFF_FFFF,  OP_DIV,  32'h8000_0000,  32'h0};
        vecs[4]  = '{32'd5,          32'd0,          OP_DIVU, 32'hFFFF_FFFF,  32'd5};
        vecs[5]  = '{32'd5,          32'd0,          OP_DIV,  32'hFFFF_FFFF,  32'd5};
        vecs[6]  = '{32'hFFFF_FFFB,  32'd0,          OP_REM,  32'hFFFF_FFFF,  32'hFFFF_FFFB};
        vecs[7]  = '{32'hFFFF_FFFF,  32'h10,         OP_REMU, 32'h0FFF_FFFF,  32'hF};
        vecs[8]  = '{32'd3,          32'd10,         OP_DIVU, 32'h0,          32'd3};
        vecs[9]  = '{32'd7,          32'hFFFF_FFFE,  OP_DIV,  32'hFFFF_FFFD,  32'd1};
        vecs[10] = '{32'hFFFF_FFF9,  32'hFFFF_FFFE,  OP_REM,  32'd3,          32'hFFFF_FFFF};
        vecs[11] = '{32'h8000_0000,  32'hFFFF_FFFF,  OP_DIVU, 32'h0,          32'h8000_0000};
        vecs[12] = '{32'h0,          32'h8000_0000,  OP_DIV,  32'h0,          32'h0};

        #12;
        check("reset_quotient", quotient, 32'h0);
        check("reset_remainder", remainder, 32'h0);
        check("reset_done", {31'b0, done}, 32'h0);
        @(negedge clk_in);
        reset_in = 1'b0;
        @(negedge clk_in);

        // table vectors, each issued in the previous done cycle
        for (int i = 0; i < 13; i++) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].o, vecs[i].q, vecs[i].r);
            wait_done(40);
        end

        // start at cycle 10 during CALC must be ignored
        issue(32'd100, 32'd7, OP_DIVU, 32'd14, 32'd2);
        repeat (9) @(posedge clk_in);
        #1;
        rs1 = 32'd9; rs2 = 32'd1; op = OP_DIV; start = 1'b1;
        @(posedge clk_in);
        #1;
        start = 1'b0;
        wait_done(40);
        issue(32'd1000, 32'hFFFF_FFFD, OP_DIV, 32'hFFFF_FEB3, 32'd1);
        wait_done(40);

        // asynchronous reset mid-operation
        issue(32'hFFFF_FFFF, 32'd3, OP_DIVU, 32'h5555_5555, 32'h0);
        repeat (14) @(posedge clk_in);
        #2;
        reset_in = 1'b1;
        #1;
        check("async_rst_quotient", quotient, 32'h0);
        check("async_rst_remainder", remainder, 32'h0);
        check("async_rst_done", {31'b0, done}, 32'h0);
        sb.delete();
        repeat (3) @(posedge clk_in);
        #1;
        reset_in = 1'b0;
        ndone = 0;
        repeat (40) begin
            @(negedge clk_in);
            if (done) ndone++;
        end
        check("no_done_after_abort", 32'(ndone), 32'h0);
        issue(32'd77, 32'd5, OP_REMU, 32'd15, 32'd2);
        wait_done(40);

        for (int i = 0; i < 1500; i++) begin
            issue_ref(pick(), pick(), 2'($urandom));
            wait_done(40);
        end

        repeat (3) @(negedge clk_in);
        check("scoreboard_empty", 32'(sb.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
